// File: rtl/leaf_stream_tx.sv
`default_nettype none
// ============================================================================
// leaf_stream_tx : credit-controlled packetizer, 32-bit stream -> 49-bit BFT
// Rev 1.0
// ============================================================================
module leaf_stream_tx #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 4,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int MY_LEAF            = 3,
  parameter int MY_PORT            = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]      dest_port,
  input  logic [PAYLOAD_BITS-1:0]       Input_V_TDATA,
  input  logic                          Input_V_TVALID,
  output logic                          Input_V_TREADY,
  input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits,
  output logic                          idle
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int VALID_BIT   = PACKET_BITS - 1;
  localparam int LEAF_LSB    = VALID_BIT - NUM_LEAF_BITS;
  localparam int PORT_LSB    = LEAF_LSB - NUM_PORT_BITS;
  localparam logic [CREDIT_BITS-1:0] DEPTH     = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);
  localparam logic [CREDIT_BITS:0]   DEPTH_EXT = (CREDIT_BITS+1)'(1 << NUM_BRAM_ADDR_BITS);

  logic [NUM_BRAM_ADDR_BITS-1:0] addr;
  logic [PACKET_BITS-1:0]        dout_next;
  logic [CREDIT_BITS-1:0]        credits_next;
  logic [CREDIT_BITS-1:0]        inc;
  logic [CREDIT_BITS:0]          credit_sum;
  logic                          hold;
  logic                          accept;
  logic                          update_hit;
  logic                          unused_din_bits;

  // A rejected packet must stay on the wire, so nothing new may be taken.
  assign hold           = dout_leaf_interface2bft[VALID_BIT] & resend;
  assign Input_V_TREADY = ap_rst_n & ap_start & (credits != '0) & ~hold;
  assign accept         = Input_V_TVALID & Input_V_TREADY;

  // Freespace updates arrive on the control port (0) tagged with our port index.
  assign update_hit =
      din_leaf_bft2interface[VALID_BIT] &
      (din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(MY_LEAF)) &
      (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0) &
      (din_leaf_bft2interface[PAYLOAD_BITS-1 -: NUM_PORT_BITS] == NUM_PORT_BITS'(MY_PORT));

  assign inc = update_hit ? din_leaf_bft2interface[CREDIT_BITS-1:0] : '0;

  assign credit_sum   = {1'b0, credits} + {1'b0, inc} - (CREDIT_BITS+1)'(accept);
  assign credits_next = (credit_sum > DEPTH_EXT) ? DEPTH : credit_sum[CREDIT_BITS-1:0];

  assign unused_din_bits = ^{din_leaf_bft2interface[PORT_LSB-1:PAYLOAD_BITS],
                             din_leaf_bft2interface[PAYLOAD_BITS-NUM_PORT_BITS-1:CREDIT_BITS]};

  always_comb begin
    dout_next = dout_leaf_interface2bft;
    if (accept) begin
      dout_next = {1'b1, dest_leaf, dest_port, addr, 1'b0, Input_V_TDATA};
    end else if (!hold) begin
      dout_next[VALID_BIT] = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_leaf_interface2bft <= '0;
      credits                 <= DEPTH;
      addr                    <= '0;
    end else begin
      dout_leaf_interface2bft <= dout_next;
      credits                 <= credits_next;
      if (accept) begin
        addr <= addr + 1'b1;
      end
    end
  end

  assign idle = ~dout_leaf_interface2bft[VALID_BIT] & (credits == DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_tx.sv
`default_nettype none
// ============================================================================
// tb_leaf_stream_tx : vector table, corner sequences and random run vs model
// Rev 1.0
// ============================================================================
module tb_leaf_stream_tx;

  localparam int MY_LEAF = 3;
  localparam int MY_PORT = 1;

  logic        clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic [3:0]  dest_leaf = 4'd2;
  logic [3:0]  dest_port = 4'd1;
  logic [31:0] Input_V_TDATA = '0;
  logic        Input_V_TVALID = 1'b0;
  logic        Input_V_TREADY;
  logic [48:0] din = '0;
  logic [48:0] dout;
  logic        resend = 1'b0;
  logic [7:0]  credits;
  logic        idle;

  leaf_stream_tx #(
    .MY_LEAF (MY_LEAF),
    .MY_PORT (MY_PORT)
  ) dut (
    .ap_clk                  (clk),
    .ap_rst_n                (ap_rst_n),
    .ap_start                (ap_start),
    .dest_leaf               (dest_leaf),
    .dest_port               (dest_port),
    .Input_V_TDATA           (Input_V_TDATA),
    .Input_V_TVALID          (Input_V_TVALID),
    .Input_V_TREADY          (Input_V_TREADY),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .credits                 (credits),
    .idle                    (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: credit count, next address, word currently on the wire.
  int          m_cred = 128;
  int          m_addr = 0;
  logic [48:0] m_dout = '0;
  logic        dut_rdy;
  logic        dut_acc;

  typedef struct {
    logic        st;
    logic        tv;
    logic [31:0] d;
    logic        rs;
    logic [48:0] dn;
    logic        rdy;
    logic [48:0] exp_dout;
    logic [7:0]  cred;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [48:0] pkt(input logic v, input logic [3:0] l, input logic [3:0] p,
                                      input logic [6:0] a, input logic [31:0] d);
    return {v, l, p, a, 1'b0, d};
  endfunction

  function automatic logic [48:0] raw_upd(input logic v, input logic [3:0] l, input logic [3:0] p,
                                          input logic [3:0] tag, input logic [7:0] inc);
    return {v, l, p, 7'd0, 1'b0, tag, 20'd0, inc};
  endfunction

  function automatic logic [48:0] upd(input logic [7:0] inc);
    return raw_upd(1'b1, 4'(MY_LEAF), 4'd0, 4'(MY_PORT), inc);
  endfunction

  function automatic bit is_update(input logic [48:0] p);
    return p[48] && p[47:44] == 4'(MY_LEAF) && p[43:40] == 4'd0 && p[31:28] == 4'(MY_PORT);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic tv, input logic [31:0] d,
                      input logic rs, input logic [48:0] dn);
    logic exp_rdy;
    logic acc;
    int   inc;
    @(negedge clk);
    ap_start = st; Input_V_TVALID = tv; Input_V_TDATA = d; resend = rs; din = dn;
    #1;
    exp_rdy = st && (m_cred != 0) && !(m_dout[48] && rs);
    dut_rdy = Input_V_TREADY;
    dut_acc = tv & Input_V_TREADY;
    chk("tready", 64'(Input_V_TREADY), 64'(exp_rdy));
    acc = tv && exp_rdy;
    inc = is_update(dn) ? int'(dn[7:0]) : 0;
    @(posedge clk);
    if (acc) begin
      m_dout = {1'b1, dest_leaf, dest_port, 7'(m_addr), 1'b0, d};
      m_addr = (m_addr + 1) % 128;
    end else if (!(m_dout[48] && rs)) begin
      m_dout[48] = 1'b0;
    end
    m_cred = m_cred + inc - (acc ? 1 : 0);
    if (m_cred > 128) m_cred = 128;
    #1;
    chk("dout", 64'(dout), 64'(m_dout));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("idle", 64'(idle), 64'(!m_dout[48] && m_cred == 128));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_credits", 64'(credits), 64'd128);
    chk("rst_tready", 64'(Input_V_TREADY), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    m_cred = 128; m_addr = 0; m_dout = '0;
    repeat (2) @(posedge clk);
    #2;
    ap_rst_n = 1'b1;
  endtask

  task automatic top_up();
    step(1'b1, 1'b0, 32'd0, 1'b0, upd(8'd128));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'hA5A50001, 1'b0, 49'd0, 1'b1, pkt(1'b1, 4'd2, 4'd1, 7'd0, 32'hA5A50001), 8'd127};
    tbl[1]  = '{1'b1, 1'b1, 32'h11, 1'b1, 49'd0, 1'b0, pkt(1'b1, 4'd2, 4'd1, 7'd0, 32'hA5A50001), 8'd127};
    tbl[2]  = '{1'b1, 1'b1, 32'h22, 1'b0, 49'd0, 1'b1, pkt(1'b1, 4'd2, 4'd1, 7'd1, 32'h22), 8'd126};
    tbl[3]  = '{1'b1, 1'b0, 32'h0, 1'b0, 49'd0, 1'b1, pkt(1'b0, 4'd2, 4'd1, 7'd1, 32'h22), 8'd126};
    tbl[4]  = '{1'b1, 1'b1, 32'h33, 1'b1, 49'd0, 1'b1, pkt(1'b1, 4'd2, 4'd1, 7'd2, 32'h33), 8'd125};
    tbl[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, upd(8'd3), 1'b1, pkt(1'b0, 4'd2, 4'd1, 7'd2, 32'h33), 8'd128};
    tbl[6]  = '{1'b0, 1'b1, 32'h55, 1'b0, 49'd0, 1'b0, pkt(1'b0, 4'd2, 4'd1, 7'd2, 32'h33), 8'd128};
    tbl[7]  = '{1'b1, 1'b1, 32'h44, 1'b0, raw_upd(1'b1, 4'd4, 4'd0, 4'd1, 8'd1), 1'b1,
                pkt(1'b1, 4'd2, 4'd1, 7'd3, 32'h44), 8'd127};
    tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, raw_upd(1'b1, 4'd3, 4'd1, 4'd1, 8'd1), 1'b1,
                pkt(1'b0, 4'd2, 4'd1, 7'd3, 32'h44), 8'd127};
    tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, raw_upd(1'b1, 4'd3, 4'd0, 4'd2, 8'd1), 1'b1,
                pkt(1'b0, 4'd2, 4'd1, 7'd3, 32'h44), 8'd127};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b0, raw_upd(1'b0, 4'd3, 4'd0, 4'd1, 8'd1), 1'b1,
                pkt(1'b0, 4'd2, 4'd1, 7'd3, 32'h44), 8'd127};
    tbl[11] = '{1'b1, 1'b0, 32'h0, 1'b0, upd(8'd1), 1'b1, pkt(1'b0, 4'd2, 4'd1, 7'd3, 32'h44), 8'd128};

    // Reset with a word already presented; it must not be taken during reset.
    ap_start = 1'b1; Input_V_TVALID = 1'b1; Input_V_TDATA = 32'hA5A50001;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].tv, tbl[i].d, tbl[i].rs, tbl[i].dn);
      chk($sformatf("tbl%0d_rdy", i), 64'(dut_rdy), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_dout", i), 64'(dout), 64'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_cred", i), 64'(credits), 64'(tbl[i].cred));
    end

    // Drain to 50 credits, then an asynchronous reset drops everything.
    for (int i = 0; i < 200 && m_cred > 50; i++) step(1'b1, 1'b1, 32'(i), 1'b0, 49'd0);
    chk("pre_rst_cred", 64'(credits), 64'd50);
    do_reset();
    step(1'b1, 1'b1, 32'hBEEF0000, 1'b0, 49'd0);
    chk("post_rst_addr", 64'(dout[39:33]), 64'd0);
    chk("post_rst_cred", 64'(credits), 64'd127);

    // Exhaust credits from a fresh start, then refill by two and wrap the address.
    do_reset();
    begin
      int n_acc = 0;
      for (int i = 0; i < 130; i++) begin
        step(1'b1, 1'b1, 32'h1000_0000 + 32'(i), 1'b0, 49'd0);
        if (dut_acc) begin
          chk("stream_addr", 64'(dout[39:33]), 64'(n_acc % 128));
          n_acc++;
        end
      end
      chk("stream_count", 64'(n_acc), 64'd128);
      chk("stream_cred0", 64'(credits), 64'd0);
      step(1'b1, 1'b1, 32'hCAFE0000, 1'b0, upd(8'd2));
      chk("upd_cycle_rdy", 64'(dut_rdy), 64'd0);
      chk("upd_cred", 64'(credits), 64'd2);
      step(1'b1, 1'b1, 32'hCAFE0001, 1'b0, 49'd0);
      chk("wrap_addr0", 64'(dout[39:33]), 64'd0);
      step(1'b1, 1'b1, 32'hCAFE0002, 1'b0, 49'd0);
      chk("wrap_addr1", 64'(dout[39:33]), 64'd1);
      step(1'b1, 1'b1, 32'hCAFE0003, 1'b0, 49'd0);
      chk("restall_rdy", 64'(dut_rdy), 64'd0);
    end

    // Hold the addr-5 packet through three consecutive resends.
    top_up();
    for (int i = 0; i < 200 && !(m_dout[48] && m_dout[39:33] == 7'd5); i++)
      step(1'b1, 1'b1, 32'h2000_0000 + 32'(i), 1'b0, 49'd0);
    begin
      logic [48:0] held;
      held = dout;
      chk("rs_start_addr", 64'(held[39:33]), 64'd5);
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b1, 32'h3000_0000 + 32'(i), 1'b1, 49'd0);
        chk("rs_rdy", 64'(dut_rdy), 64'd0);
        chk("rs_hold", 64'(dout), 64'(held));
      end
      step(1'b1, 1'b1, 32'h3000_00FF, 1'b0, 49'd0);
      chk("rs_next_addr", 64'(dout[39:33]), 64'd6);
    end

    // Simultaneous send and update, then saturation.
    top_up();
    for (int i = 0; i < 200 && m_cred > 10; i++) step(1'b1, 1'b1, 32'(i), 1'b0, 49'd0);
    chk("pre_mix_cred", 64'(credits), 64'd10);
    step(1'b1, 1'b1, 32'h4000_0000, 1'b0, upd(8'd1));
    chk("mix_cred", 64'(credits), 64'd10);
    step(1'b1, 1'b0, 32'd0, 1'b0, upd(8'd90));
    chk("cred100", 64'(credits), 64'd100);
    step(1'b1, 1'b0, 32'd0, 1'b0, upd(8'd128));
    chk("sat_cred", 64'(credits), 64'd128);

    // Random traffic against the reference model.
    dest_leaf = 4'($urandom_range(0, 15));
    dest_port = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) begin
      logic [48:0] dn;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2)       dn = upd(8'($urandom_range(0, 128)));
      else if (sel == 2) dn = raw_upd(1'b1, 4'(MY_LEAF + 1), 4'd0, 4'(MY_PORT), 8'($urandom_range(0, 128)));
      else begin
        dn = {$urandom, $urandom};
        dn[47:44] = 4'(MY_LEAF + 2);
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 9) < 3, dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/leaf_stream_tx.md
Name: leaf_stream_tx

Overview:
Transmit-side packetizer for one user output stream. It converts a 32-bit valid/ready stream into 49-bit BFT packets addressed to a fixed destination leaf/port. It enforces credit-based flow control against the receiver's 2^NUM_BRAM_ADDR_BITS-deep input buffer and consumes freespace-update packets returned over the BFT. It sits between a user kernel output and the leaf's BFT port, as the sender counterpart of the leaf receive path.

Parameters:
PACKET_BITS, 49, BFT packet width
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 4, leaf address width
NUM_PORT_BITS, 4, port address width
NUM_BRAM_ADDR_BITS, 7, receiver buffer address width; DEPTH = 128
MY_LEAF, 3, this leaf's address, used to match freespace updates
MY_PORT, 1, this sender's port index, used to match freespace updates

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  enable; when low, no new words are accepted
dest_leaf  in  4  destination leaf; static while ap_start=1
dest_port  in  4  destination port; static while ap_start=1
Input_V_TDATA  in  32  user payload
Input_V_TVALID  in  1  payload valid
Input_V_TREADY  out  1  payload accepted when high with TVALID
din_leaf_bft2interface  in  49  incoming BFT packet (carries freespace updates)
dout_leaf_interface2bft  out  49  outgoing BFT packet, registered
resend  in  1  BFT rejected the current outgoing packet
credits  out  8  current credit count, 0..128
idle  out  1  high when no packet is pending and credits=128

Behaviour:
- Packet format (both directions):
  - [48] valid
  - [47:44] dest leaf
  - [43:40] dest port
  - [39:33] addr
  - [32] reserved, always 0
  - [31:0] payload
- Reset (async, ap_rst_n=0): dout=49'd0, credits=128, addr counter=0, TREADY=0, idle=1. Reset asserted mid-packet drops the pending packet with no replay.
- TREADY is combinational: ap_start & (credits!=0) & ~(dout[48] & resend).
- Accept (TVALID & TREADY) in cycle N. In cycle N+1, dout = {1, dest_leaf, dest_port, addr, 0, TDATA}. addr increments mod 128 (127 wraps to 0). credits decrements by 1.
- No accept in a cycle: dout[48] is cleared next cycle, unless resend holds it.
- Resend:
  - resend=1 while dout[48]=1: dout holds its value next cycle and TREADY=0 this cycle.
  - Consecutive resends hold the packet indefinitely.
  - resend while dout[48]=0 is ignored.
- Freespace update: din[48]=1, din[47:44]=MY_LEAF, din[43:40]=0 (control port), din[31:28]=MY_PORT. The increment is din[7:0] and is valid from 0 to 128.
- Credit arithmetic: next = credits − send + inc, computed 9 bits wide and saturated at 128. Send and update in the same cycle both take effect.
- credits=0: TREADY=0. The stall lasts until an update arrives, and a word is accepted no earlier than the cycle after the update.
- Non-matching din packets are ignored, including valid packets for other leaves or ports and a matching leaf with nonzero port.
- idle = ~dout[48] & (credits==128).
- ap_start falling mid-stream: the in-flight dout packet still completes, including any resends. No further accepts occur.

Test Plan:
1. Reset with ap_start=1, TVALID=1, TDATA=0xA5A5_0001, dest_leaf=2, dest_port=1 -> next cycle dout = {1,4'h2,4'h1,7'd0,1'b0,32'hA5A50001}; credits=127.
2. Stream 130 words with no updates -> 128 accepted with addr 0..127, then TREADY=0 and credits=0. Inject an update with inc=2 -> 2 more accepted with addr 0 and 1 (wrap).
3. Assert resend for 3 cycles while the packet with addr=5 is on dout -> dout is identical for 4 consecutive cycles, TREADY=0 throughout, and the next word is sent with addr=6.
4. Accept a word in the same cycle as an update with inc=1 at credits=10 -> credits stays 10. Update inc=128 at credits=100 -> credits saturates at 128.
5. Updates to leaf 4, to port 1 of MY_LEAF, and with din[31:28]≠MY_PORT -> credits unchanged.
6. Deassert ap_rst_n mid-stream with credits=50 -> dout=0 and credits=128 immediately (async). The first packet after reset carries addr=0.
